// File: rtl/rs_station_if.sv
// Interface bundling the rdy/flush controls, the issuer packet, the two result
// buses snooped for wakeup and the dispatch port towards the ALU.
interface rs_station_if #(
   parameter int ROB_ID_WIDTH = 4,
   parameter int XLEN         = 32,
   parameter int OP_WIDTH     = 6,
   parameter int IMM_WIDTH    = 32
);
   logic                    rdy;
   logic                    clear_from_ro_buffer;
   logic [ROB_ID_WIDTH-1:0] dest_from_issuer;
   logic [OP_WIDTH-1:0]     op_from_issuer;
   logic [ROB_ID_WIDTH-1:0] qj_from_issuer;
   logic [ROB_ID_WIDTH-1:0] qk_from_issuer;
   logic [XLEN-1:0]         vj_from_issuer;
   logic [XLEN-1:0]         vk_from_issuer;
   logic [IMM_WIDTH-1:0]    imm_from_issuer;
   logic [XLEN-1:0]         pc_from_issuer;
   logic [ROB_ID_WIDTH-1:0] dest_from_rss_bus;
   logic [XLEN-1:0]         value_from_rss_bus;
   logic [ROB_ID_WIDTH-1:0] dest_from_lsb_bus;
   logic [XLEN-1:0]         value_from_lsb_bus;
   logic                    is_full;
   logic                    valid_to_alu;
   logic [OP_WIDTH-1:0]     op_to_alu;
   logic [XLEN-1:0]         vj_to_alu;
   logic [XLEN-1:0]         vk_to_alu;
   logic [IMM_WIDTH-1:0]    imm_to_alu;
   logic [XLEN-1:0]         pc_to_alu;
   logic [ROB_ID_WIDTH-1:0] dest_to_alu;

   // Reservation-station side
   modport slave (
      input  rdy, clear_from_ro_buffer,
      input  dest_from_issuer, op_from_issuer, qj_from_issuer, qk_from_issuer,
      input  vj_from_issuer, vk_from_issuer, imm_from_issuer, pc_from_issuer,
      input  dest_from_rss_bus, value_from_rss_bus, dest_from_lsb_bus, value_from_lsb_bus,
      output is_full, valid_to_alu, op_to_alu, vj_to_alu, vk_to_alu,
      output imm_to_alu, pc_to_alu, dest_to_alu
   );

   // Environment side (issuer, result buses, ALU)
   modport master (
      output rdy, clear_from_ro_buffer,
      output dest_from_issuer, op_from_issuer, qj_from_issuer, qk_from_issuer,
      output vj_from_issuer, vk_from_issuer, imm_from_issuer, pc_from_issuer,
      output dest_from_rss_bus, value_from_rss_bus, dest_from_lsb_bus, value_from_lsb_bus,
      input  is_full, valid_to_alu, op_to_alu, vj_to_alu, vk_to_alu,
      input  imm_to_alu, pc_to_alu, dest_to_alu
   );
endinterface

// File: rtl/rs_station.sv
// Reservation station for non-memory instructions. Captures issued packets
// into the lowest free slot, wakes pending operands from the ALU (rss) and
// load (lsb) result buses, and dispatches the lowest ready slot to the ALU.
module rs_station #(
   parameter int RS_SIZE      = 16,
   parameter int ROB_ID_WIDTH = 4,
   parameter int XLEN         = 32,
   parameter int OP_WIDTH     = 6,
   parameter int IMM_WIDTH    = 32
) (
   input logic          clk,
   input logic          rst,
   rs_station_if.slave  bus
);

   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [ROB_ID_WIDTH-1:0] TAG_NONE = {ROB_ID_WIDTH{1'b0}};
   localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Entry storage
   logic                    busy_r [RS_SIZE];
   logic [OP_WIDTH-1:0]     op_r   [RS_SIZE];
   logic [ROB_ID_WIDTH-1:0] qj_r   [RS_SIZE];
   logic [ROB_ID_WIDTH-1:0] qk_r   [RS_SIZE];
   logic [XLEN-1:0]         vj_r   [RS_SIZE];
   logic [XLEN-1:0]         vk_r   [RS_SIZE];
   logic [IMM_WIDTH-1:0]    imm_r  [RS_SIZE];
   logic [XLEN-1:0]         pc_r   [RS_SIZE];
   logic [ROB_ID_WIDTH-1:0] dest_r [RS_SIZE];

   // Dispatch output registers
   logic                    valid_r;
   logic [OP_WIDTH-1:0]     op_out_r;
   logic [XLEN-1:0]         vj_out_r;
   logic [XLEN-1:0]         vk_out_r;
   logic [IMM_WIDTH-1:0]    imm_out_r;
   logic [XLEN-1:0]         pc_out_r;
   logic [ROB_ID_WIDTH-1:0] dest_out_r;

   // Slot selection
   logic [CNT_W-1:0]        free_cnt_s;
   logic                    free_found_s;
   logic [IDX_W-1:0]        free_idx_s;
   logic                    ready_found_s;
   logic [IDX_W-1:0]        ready_idx_s;
   logic                    issue_en_s;
   logic [ROB_ID_WIDTH+XLEN-1:0] issue_j_s;
   logic [ROB_ID_WIDTH+XLEN-1:0] issue_k_s;

   // Resolve one operand against the result buses; rss wins over lsb, and a
   // zero tag is already valid so it can never match an idle bus.
   function automatic logic [ROB_ID_WIDTH+XLEN-1:0] resolve_operand(
      input logic [ROB_ID_WIDTH-1:0] q,
      input logic [XLEN-1:0]         v,
      input logic [ROB_ID_WIDTH-1:0] rss_tag,
      input logic [XLEN-1:0]         rss_val,
      input logic [ROB_ID_WIDTH-1:0] lsb_tag,
      input logic [XLEN-1:0]         lsb_val
   );
      logic [ROB_ID_WIDTH+XLEN-1:0] res;
      if (q == TAG_NONE) begin
         res = {q, v};
      end else if (q == rss_tag) begin
         res = {TAG_NONE, rss_val};
      end else if (q == lsb_tag) begin
         res = {TAG_NONE, lsb_val};
      end else begin
         res = {q, v};
      end
      return res;
   endfunction

   // Count free slots and find the lowest free and lowest ready slot from start-of-cycle state
   always_comb begin
      free_cnt_s    = CNT_ZERO;
      free_found_s  = 1'b0;
      free_idx_s    = {IDX_W{1'b0}};
      ready_found_s = 1'b0;
      ready_idx_s   = {IDX_W{1'b0}};
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_r[i]) begin
            free_cnt_s   = free_cnt_s + CNT_ONE;
            free_found_s = 1'b1;
            free_idx_s   = IDX_W'(i);
         end else if ((qj_r[i] == TAG_NONE) && (qk_r[i] == TAG_NONE)) begin
            ready_found_s = 1'b1;
            ready_idx_s   = IDX_W'(i);
         end else begin
            ready_found_s = ready_found_s;
         end
      end
   end

   // Issue qualification and same-cycle operand bypass from the result buses
   always_comb begin
      issue_en_s = bus.rdy && !bus.clear_from_ro_buffer &&
                   (bus.dest_from_issuer != TAG_NONE) && free_found_s;
      issue_j_s  = resolve_operand(bus.qj_from_issuer, bus.vj_from_issuer,
                                   bus.dest_from_rss_bus, bus.value_from_rss_bus,
                                   bus.dest_from_lsb_bus, bus.value_from_lsb_bus);
      issue_k_s  = resolve_operand(bus.qk_from_issuer, bus.vk_from_issuer,
                                   bus.dest_from_rss_bus, bus.value_from_rss_bus,
                                   bus.dest_from_lsb_bus, bus.value_from_lsb_bus);
   end

   // Entry state and dispatch registers: reset > flush > stall > issue/wakeup/dispatch
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            busy_r[i] <= 1'b0;
            op_r[i]   <= {OP_WIDTH{1'b0}};
            qj_r[i]   <= TAG_NONE;
            qk_r[i]   <= TAG_NONE;
            vj_r[i]   <= {XLEN{1'b0}};
            vk_r[i]   <= {XLEN{1'b0}};
            imm_r[i]  <= {IMM_WIDTH{1'b0}};
            pc_r[i]   <= {XLEN{1'b0}};
            dest_r[i] <= TAG_NONE;
         end
         valid_r    <= 1'b0;
         op_out_r   <= {OP_WIDTH{1'b0}};
         vj_out_r   <= {XLEN{1'b0}};
         vk_out_r   <= {XLEN{1'b0}};
         imm_out_r  <= {IMM_WIDTH{1'b0}};
         pc_out_r   <= {XLEN{1'b0}};
         dest_out_r <= TAG_NONE;
      end else if (bus.clear_from_ro_buffer) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            busy_r[i] <= 1'b0;
         end
         valid_r <= 1'b0;
      end else if (!bus.rdy) begin
         valid_r <= 1'b0;
      end else begin
         // Wakeup of pending operands in busy entries
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_r[i]) begin
               {qj_r[i], vj_r[i]} <= resolve_operand(qj_r[i], vj_r[i],
                                        bus.dest_from_rss_bus, bus.value_from_rss_bus,
                                        bus.dest_from_lsb_bus, bus.value_from_lsb_bus);
               {qk_r[i], vk_r[i]} <= resolve_operand(qk_r[i], vk_r[i],
                                        bus.dest_from_rss_bus, bus.value_from_rss_bus,
                                        bus.dest_from_lsb_bus, bus.value_from_lsb_bus);
            end
         end
         // Dispatch the lowest ready entry; its slot becomes free from the next cycle
         if (ready_found_s) begin
            busy_r[ready_idx_s] <= 1'b0;
            valid_r    <= 1'b1;
            op_out_r   <= op_r[ready_idx_s];
            vj_out_r   <= vj_r[ready_idx_s];
            vk_out_r   <= vk_r[ready_idx_s];
            imm_out_r  <= imm_r[ready_idx_s];
            pc_out_r   <= pc_r[ready_idx_s];
            dest_out_r <= dest_r[ready_idx_s];
         end else begin
            valid_r <= 1'b0;
         end
         // Issue into the lowest slot free at the start of the cycle (never the dispatched one)
         if (issue_en_s) begin
            busy_r[free_idx_s] <= 1'b1;
            op_r[free_idx_s]   <= bus.op_from_issuer;
            {qj_r[free_idx_s], vj_r[free_idx_s]} <= issue_j_s;
            {qk_r[free_idx_s], vk_r[free_idx_s]} <= issue_k_s;
            imm_r[free_idx_s]  <= bus.imm_from_issuer;
            pc_r[free_idx_s]   <= bus.pc_from_issuer;
            dest_r[free_idx_s] <= bus.dest_from_issuer;
         end
      end
   end

   // Full when nothing is free, or when the last free slot is claimed by the packet
   // the issuer is presenting now (the issuer sees this one cycle late).
   assign bus.is_full = (free_cnt_s == CNT_ZERO) ||
                        ((free_cnt_s == CNT_ONE) && (bus.dest_from_issuer != TAG_NONE));

   assign bus.valid_to_alu = valid_r;
   assign bus.op_to_alu    = op_out_r;
   assign bus.vj_to_alu    = vj_out_r;
   assign bus.vk_to_alu    = vk_out_r;
   assign bus.imm_to_alu   = imm_out_r;
   assign bus.pc_to_alu    = pc_out_r;
   assign bus.dest_to_alu  = dest_out_r;

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: reset, issue/dispatch latency, wakeup and
// bypass, full detection and ordered drain, flush and stall.
module tb_rs_station;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rs_station_if #(.ROB_ID_WIDTH(4), .XLEN(32), .OP_WIDTH(6), .IMM_WIDTH(32)) bus ();

   rs_station #(
      .RS_SIZE(16), .ROB_ID_WIDTH(4), .XLEN(32), .OP_WIDTH(6), .IMM_WIDTH(32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.dest_from_issuer   = 4'd0;
      bus.op_from_issuer     = 6'd0;
      bus.qj_from_issuer     = 4'd0;
      bus.qk_from_issuer     = 4'd0;
      bus.vj_from_issuer     = 32'd0;
      bus.vk_from_issuer     = 32'd0;
      bus.imm_from_issuer    = 32'd0;
      bus.pc_from_issuer     = 32'd0;
      bus.dest_from_rss_bus  = 4'd0;
      bus.value_from_rss_bus = 32'd0;
      bus.dest_from_lsb_bus  = 4'd0;
      bus.value_from_lsb_bus = 32'd0;
   endtask

   task automatic issue(input logic [3:0] dest, input logic [5:0] op,
                        input logic [3:0] qj, input logic [3:0] qk,
                        input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] imm, input logic [31:0] pc);
      bus.dest_from_issuer = dest;
      bus.op_from_issuer   = op;
      bus.qj_from_issuer   = qj;
      bus.qk_from_issuer   = qk;
      bus.vj_from_issuer   = vj;
      bus.vk_from_issuer   = vk;
      bus.imm_from_issuer  = imm;
      bus.pc_from_issuer   = pc;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // 1. Reset with a packet present: nothing is captured
      rst = 1'b1;
      bus.rdy = 1'b1;
      bus.clear_from_ro_buffer = 1'b0;
      idle();
      bus.dest_from_issuer = 4'd5;
      step();
      step();
      rst = 1'b0;
      idle();
      #1;
      chk("rst_valid", 64'(bus.valid_to_alu), 64'd0);
      chk("rst_op",    64'(bus.op_to_alu),    64'd0);
      chk("rst_vj",    64'(bus.vj_to_alu),    64'd0);
      chk("rst_vk",    64'(bus.vk_to_alu),    64'd0);
      chk("rst_imm",   64'(bus.imm_to_alu),   64'd0);
      chk("rst_pc",    64'(bus.pc_to_alu),    64'd0);
      chk("rst_dest",  64'(bus.dest_to_alu),  64'd0);
      chk("rst_full",  64'(bus.is_full),      64'd0);
      step();
      chk("rst_nodisp1", 64'(bus.valid_to_alu), 64'd0);
      step();
      chk("rst_nodisp2", 64'(bus.valid_to_alu), 64'd0);

      // 2. Ready issue: dispatched one edge after capture, single pulse
      issue(4'd3, 6'h0A, 4'd0, 4'd0, 32'd7, 32'd9, 32'h100, 32'h1000);
      step();
      idle();
      chk("rdy_issue_edge", 64'(bus.valid_to_alu), 64'd0);
      step();
      chk("rdy_valid", 64'(bus.valid_to_alu), 64'd1);
      chk("rdy_dest",  64'(bus.dest_to_alu),  64'd3);
      chk("rdy_vj",    64'(bus.vj_to_alu),    64'd7);
      chk("rdy_vk",    64'(bus.vk_to_alu),    64'd9);
      chk("rdy_op",    64'(bus.op_to_alu),    64'h0A);
      chk("rdy_imm",   64'(bus.imm_to_alu),   64'h100);
      chk("rdy_pc",    64'(bus.pc_to_alu),    64'h1000);
      step();
      chk("rdy_pulse",     64'(bus.valid_to_alu), 64'd0);
      chk("rdy_dest_hold", 64'(bus.dest_to_alu),  64'd3);

      // 3a. Wakeup from rss two cycles after issue
      issue(4'd4, 6'h02, 4'd2, 4'd0, 32'd0, 32'h11, 32'd0, 32'h2000);
      step();
      idle();
      step();
      chk("wk_pending", 64'(bus.valid_to_alu), 64'd0);
      bus.dest_from_rss_bus  = 4'd2;
      bus.value_from_rss_bus = 32'h55;
      step();
      idle();
      chk("wk_wake_edge", 64'(bus.valid_to_alu), 64'd0);
      step();
      chk("wk_valid", 64'(bus.valid_to_alu), 64'd1);
      chk("wk_dest",  64'(bus.dest_to_alu),  64'd4);
      chk("wk_vj",    64'(bus.vj_to_alu),    64'h55);
      chk("wk_vk",    64'(bus.vk_to_alu),    64'h11);

      // 3b. Same-cycle bypass at issue: rss for qj, lsb for qk
      issue(4'd6, 6'h03, 4'd7, 4'd8, 32'd0, 32'd0, 32'd0, 32'h3000);
      bus.dest_from_rss_bus  = 4'd7;
      bus.value_from_rss_bus = 32'hAA;
      bus.dest_from_lsb_bus  = 4'd8;
      bus.value_from_lsb_bus = 32'hBB;
      step();
      idle();
      chk("byp_issue_edge", 64'(bus.valid_to_alu), 64'd0);
      step();
      chk("byp_valid", 64'(bus.valid_to_alu), 64'd1);
      chk("byp_dest",  64'(bus.dest_to_alu),  64'd6);
      chk("byp_vj",    64'(bus.vj_to_alu),    64'hAA);
      chk("byp_vk",    64'(bus.vk_to_alu),    64'hBB);

      // 3c. Both buses carry the awaited tag: rss value wins
      issue(4'd9, 6'h04, 4'd3, 4'd0, 32'd0, 32'd1, 32'd0, 32'd0);
      step();
      idle();
      bus.dest_from_rss_bus  = 4'd3;
      bus.value_from_rss_bus = 32'h33;
      bus.dest_from_lsb_bus  = 4'd3;
      bus.value_from_lsb_bus = 32'h44;
      step();
      idle();
      chk("prio_wake_edge", 64'(bus.valid_to_alu), 64'd0);
      step();
      chk("prio_valid", 64'(bus.valid_to_alu), 64'd1);
      chk("prio_vj",    64'(bus.vj_to_alu),    64'h33);

      // 4. Fill 15 slots pending on tag 1, then check full and ordered drain
      for (int i = 0; i < 15; i++) begin
         issue(4'(2 + (i % 14)), 6'h01, 4'd1, 4'd0, 32'd0, 32'(i), 32'd0, 32'd0);
         step();
         chk("fill_no_disp", 64'(bus.valid_to_alu), 64'd0);
      end
      idle();
      #1;
      chk("full_free1_idle", 64'(bus.is_full), 64'd0);
      issue(4'd5, 6'h01, 4'd1, 4'd0, 32'd0, 32'd15, 32'd0, 32'd0);
      #1;
      chk("full_free1_issue", 64'(bus.is_full), 64'd1);
      step();
      idle();
      #1;
      chk("full_free0", 64'(bus.is_full), 64'd1);
      bus.dest_from_lsb_bus  = 4'd1;
      bus.value_from_lsb_bus = 32'h77;
      step();
      idle();
      chk("drain_wake_edge", 64'(bus.valid_to_alu), 64'd0);
      for (int k = 0; k < 16; k++) begin
         step();
         chk("drain_valid", 64'(bus.valid_to_alu), 64'd1);
         chk("drain_order", 64'(bus.vk_to_alu),    64'(k));
         chk("drain_vj",    64'(bus.vj_to_alu),    64'h77);
         if (k == 0) begin
            chk("drain_not_full", 64'(bus.is_full), 64'd0);
         end
      end
      step();
      chk("drain_done", 64'(bus.valid_to_alu), 64'd0);

      // 5. Flush with 6 busy entries (last one ready), a coincident issue and rss wakeup
      for (int i = 0; i < 5; i++) begin
         issue(4'(2 + i), 6'h05, 4'd3, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
         step();
      end
      issue(4'd12, 6'h05, 4'd0, 4'd0, 32'd1, 32'd2, 32'd0, 32'd0);
      step();
      bus.clear_from_ro_buffer = 1'b1;
      issue(4'd7, 6'h06, 4'd0, 4'd0, 32'd5, 32'd6, 32'd0, 32'd0);
      bus.dest_from_rss_bus  = 4'd3;
      bus.value_from_rss_bus = 32'h99;
      step();
      bus.clear_from_ro_buffer = 1'b0;
      idle();
      #1;
      chk("flush_valid", 64'(bus.valid_to_alu), 64'd0);
      chk("flush_full",  64'(bus.is_full),      64'd0);
      bus.dest_from_rss_bus  = 4'd3;
      bus.value_from_rss_bus = 32'h99;
      step();
      idle();
      chk("flush_post1", 64'(bus.valid_to_alu), 64'd0);
      step();
      chk("flush_post2", 64'(bus.valid_to_alu), 64'd0);
      step();
      chk("flush_post3", 64'(bus.valid_to_alu), 64'd0);

      // 6. Stall for 3 cycles holding a ready entry
      issue(4'd10, 6'h07, 4'd0, 4'd0, 32'hC0, 32'hC1, 32'd0, 32'h4000);
      step();
      idle();
      bus.rdy = 1'b0;
      for (int s = 0; s < 3; s++) begin
         step();
         chk("stall_nodisp", 64'(bus.valid_to_alu), 64'd0);
      end
      bus.rdy = 1'b1;
      step();
      chk("stall_valid", 64'(bus.valid_to_alu), 64'd1);
      chk("stall_dest",  64'(bus.dest_to_alu),  64'd10);
      chk("stall_vj",    64'(bus.vj_to_alu),    64'hC0);
      step();
      chk("stall_pulse", 64'(bus.valid_to_alu), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
